// File: rtl/student_tlul_device_adapter.sv
// TL-UL device-side responder: one outstanding request, converted into a single
// handshaked register-port access with malformed-request and stall-timeout error responses.

package tlul_pkg;
   localparam logic [2:0] OP_PUT_FULL    = 3'h0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'h1;
   localparam logic [2:0] OP_GET         = 3'h4;
   localparam logic [2:0] D_ACK          = 3'h0;
   localparam logic [2:0] D_ACK_DATA     = 3'h1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic [0:0]  d_sink;
      logic [31:0] d_data;
      logic [7:0]  d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

module student_tlul_device_adapter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  tlul_pkg::tl_h2d_t     tl_i,
   output tlul_pkg::tl_d2h_t     tl_o,
   output logic                  reg_req_o,
   output logic                  reg_we_o,
   output logic [ADDR_WIDTH-1:0] reg_addr_o,
   output logic [DATA_WIDTH-1:0] reg_wdata_o,
   output logic [3:0]            reg_be_o,
   input  logic [DATA_WIDTH-1:0] reg_rdata_i,
   input  logic                  reg_ack_i,
   input  logic                  reg_error_i
);
   import tlul_pkg::*;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                state, state_nxt;
   logic [2:0]            opcode;
   logic [1:0]            size;
   logic [7:0]            source;
   logic [ADDR_WIDTH-1:0] addr;
   logic [3:0]            mask;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  we;
   logic                  error;
   logic [CW-1:0]         cnt;

   logic is_get, is_put, legal, accept, timeout;
   logic unused_tl;

   assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:ADDR_WIDTH]};

   assign is_get = (tl_i.a_opcode == OP_GET);
   assign is_put = (tl_i.a_opcode == OP_PUT_FULL) || (tl_i.a_opcode == OP_PUT_PARTIAL);
   assign legal  = (is_get || is_put)
                && (tl_i.a_size <= 2'd2)
                && (tl_i.a_address[1:0] == 2'b00)
                && !((tl_i.a_opcode == OP_PUT_FULL) && (tl_i.a_mask != 4'hF));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (tl_i.a_valid) begin
               accept    = 1'b1;
               state_nxt = legal ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            // ack takes priority over expiry in the same cycle
            if (reg_ack_i) begin
               state_nxt = RESP;
            end else if (cnt == CNT_LAST) begin
               timeout   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (tl_i.d_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         opcode <= '0;
         size   <= '0;
         source <= '0;
         addr   <= '0;
         mask   <= '0;
         wdata  <= '0;
         rdata  <= '0;
         we     <= 1'b0;
         error  <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         opcode <= tl_i.a_opcode;
         size   <= tl_i.a_size;
         source <= tl_i.a_source;
         addr   <= tl_i.a_address[ADDR_WIDTH-1:0];
         mask   <= tl_i.a_mask;
         wdata  <= tl_i.a_data[DATA_WIDTH-1:0];
         we     <= is_put;
         rdata  <= '0;
         error  <= !legal;
         cnt    <= '0;
      end else if (state == ACCESS) begin
         if (reg_ack_i) begin
            rdata <= (opcode == OP_GET) ? reg_rdata_i : '0;
            error <= reg_error_i;
         end else begin
            if (cnt != CNT_FULL) cnt <= cnt + 1'b1;
            if (timeout) begin
               rdata <= '0;
               error <= 1'b1;
            end
         end
      end
   end

   assign reg_req_o   = (state == ACCESS);
   assign reg_we_o    = we;
   assign reg_addr_o  = addr;
   assign reg_wdata_o = wdata;
   assign reg_be_o    = mask;

   always_comb begin
      tl_o          = '0;
      tl_o.a_ready  = (state == IDLE);
      tl_o.d_valid  = (state == RESP);
      tl_o.d_opcode = (opcode == OP_GET) ? D_ACK_DATA : D_ACK;
      tl_o.d_size   = size;
      tl_o.d_source = source;
      tl_o.d_data   = 32'(rdata);
      tl_o.d_error  = error;
   end

endmodule

// File: tb/tb_student_tlul_device_adapter.sv
// Scoreboard bench for student_tlul_device_adapter: directed TL-UL requests with a
// scripted register responder; a monitor checks every completed D-channel beat.

module tb_student_tlul_device_adapter;
   import tlul_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   tl_h2d_t     tl_i;
   tl_d2h_t     tl_o;
   logic        reg_req, reg_we, reg_ack, reg_error;
   logic [7:0]  reg_addr;
   logic [31:0] reg_wdata, reg_rdata;
   logic [3:0]  reg_be;

   always #5 clk = ~clk;

   student_tlul_device_adapter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i), .tl_o(tl_o),
      .reg_req_o(reg_req), .reg_we_o(reg_we), .reg_addr_o(reg_addr),
      .reg_wdata_o(reg_wdata), .reg_be_o(reg_be), .reg_rdata_i(reg_rdata),
      .reg_ack_i(reg_ack), .reg_error_i(reg_error)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] data;
      logic        err;
      logic [7:0]  src;
      logic [1:0]  size;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // register responder configuration
   logic        ack_en    = 1'b1;
   int          ack_wait  = 0;
   logic [31:0] rd_cfg    = 32'h0;
   logic        err_cfg   = 1'b0;
   int          req_cyc   = 0;
   int          req_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] sz,
                        input logic [7:0] src, input logic [3:0] mask, input logic [31:0] data,
                        output int waited);
      tl_i.a_valid   = 1'b1;
      tl_i.a_opcode  = op;
      tl_i.a_address = addr;
      tl_i.a_size    = sz;
      tl_i.a_source  = src;
      tl_i.a_mask    = mask;
      tl_i.a_data    = data;
      waited = 0;
      forever begin
         @(negedge clk);
         if (tl_o.a_ready) break;
         waited++;
         if (waited > 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_accept: a_ready low for %0d cycles, required acceptance", waited);
            break;
         end
      end
      step();
      tl_i.a_valid = 1'b0;
   endtask

   task automatic wait_dvalid(input int limit);
      int k;
      k = 0;
      while (!tl_o.d_valid && k < limit) begin
         @(negedge clk);
         k++;
      end
      if (!tl_o.d_valid) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_dvalid: d_valid=0 after %0d cycles, required 1", k);
      end
   endtask

   task automatic push(input logic [2:0] op, input logic [31:0] data, input logic err,
                       input logic [7:0] src, input logic [1:0] size);
      exp_t e;
      e.op = op; e.data = data; e.err = err; e.src = src; e.size = size;
      sb.push_back(e);
   endtask

   // register side: ack after ack_wait idle cycles of reg_req; noise outside the ack cycle
   initial begin
      reg_ack = 1'b0; reg_rdata = 32'h0; reg_error = 1'b0;
      forever begin
         step();
         if (reg_req) begin
            req_cyc++;
            req_total++;
         end else begin
            req_cyc = 0;
         end
         reg_ack   = ack_en && reg_req && (req_cyc == ack_wait + 1);
         reg_rdata = reg_ack ? rd_cfg : 32'hA5A5_A5A5;
         reg_error = reg_ack ? err_cfg : 1'b1;
      end
   end

   // monitor: every D handshake must match the oldest expected response
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && tl_o.d_valid && tl_i.d_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_resp: source 0x%0h with empty scoreboard", tl_o.d_source);
            end else begin
               e = sb.pop_front();
               chk("d_opcode", 32'(tl_o.d_opcode), 32'(e.op));
               chk("d_data",   tl_o.d_data, e.data);
               chk("d_error",  32'(tl_o.d_error), 32'(e.err));
               chk("d_source", 32'(tl_o.d_source), 32'(e.src));
               chk("d_size",   32'(tl_o.d_size), 32'(e.size));
               chk("d_param",  32'(tl_o.d_param), 0);
               chk("d_sink",   32'(tl_o.d_sink), 0);
               chk("d_user",   32'(tl_o.d_user), 0);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [2:0]  il_op[4]   = '{OP_GET - 3'd2, OP_GET, OP_PUT_FULL, OP_GET};
   logic [31:0] il_addr[4] = '{32'h10, 32'h06, 32'h0C, 32'h20};
   logic [1:0]  il_size[4] = '{2'd2, 2'd2, 2'd2, 2'd3};
   logic [3:0]  il_mask[4] = '{4'hF, 4'hF, 4'h7, 4'hF};

   initial begin
      int w;
      tl_i = '0;
      tl_i.d_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) step();
      @(negedge clk);
      chk("rst_a_ready",   32'(tl_o.a_ready), 1);
      chk("rst_d_valid",   32'(tl_o.d_valid), 0);
      chk("rst_reg_req",   32'(reg_req), 0);
      chk("rst_reg_we",    32'(reg_we), 0);
      chk("rst_reg_addr",  32'(reg_addr), 0);
      chk("rst_reg_be",    32'(reg_be), 0);
      chk("rst_reg_wdata", reg_wdata, 0);
      chk("rst_d_data",    tl_o.d_data, 0);
      chk("rst_d_error",   32'(tl_o.d_error), 0);
      chk("rst_d_opcode",  32'(tl_o.d_opcode), 0);
      step();
      rst_n = 1'b1;

      // Get with zero-wait ack: d_valid two cycles after acceptance
      step();
      ack_en = 1'b1; ack_wait = 0; rd_cfg = 32'hDEADBEEF; err_cfg = 1'b0;
      push(3'd1, 32'hDEADBEEF, 1'b0, 8'd3, 2'd2);
      issue(OP_GET, 32'h14, 2'd2, 8'd3, 4'hF, 32'h0, w);
      chk("t1_wait", w, 0);
      @(negedge clk);
      chk("t1_reg_req",  32'(reg_req), 1);
      chk("t1_reg_we",   32'(reg_we), 0);
      chk("t1_reg_addr", 32'(reg_addr), 32'h14);
      chk("t1_dv_early", 32'(tl_o.d_valid), 0);
      @(negedge clk);
      chk("t1_dv_lat2",  32'(tl_o.d_valid), 1);
      step();
      @(negedge clk);
      chk("t1_a_ready_after", 32'(tl_o.a_ready), 1);

      // PutPartialData with D back-pressure
      step();
      tl_i.d_ready = 1'b0; ack_wait = 1;
      push(3'd0, 32'h0, 1'b0, 8'd5, 2'd2);
      issue(OP_PUT_PARTIAL, 32'h08, 2'd2, 8'd5, 4'b0011, 32'h0000ABCD, w);
      @(negedge clk);
      chk("t2_reg_req",   32'(reg_req), 1);
      chk("t2_reg_we",    32'(reg_we), 1);
      chk("t2_reg_be",    32'(reg_be), 32'h3);
      chk("t2_reg_addr",  32'(reg_addr), 32'h08);
      chk("t2_reg_wdata", reg_wdata, 32'h0000ABCD);
      wait_dvalid(20);
      for (int i = 0; i < 3; i++) begin
         chk("t2_hold_dv",     32'(tl_o.d_valid), 1);
         chk("t2_hold_opcode", 32'(tl_o.d_opcode), 0);
         chk("t2_hold_source", 32'(tl_o.d_source), 5);
         chk("t2_hold_error",  32'(tl_o.d_error), 0);
         chk("t2_hold_data",   tl_o.d_data, 0);
         chk("t2_hold_a_ready", 32'(tl_o.a_ready), 0);
         if (i < 2) @(negedge clk);
      end
      step();
      tl_i.d_ready = 1'b1;
      step();
      @(negedge clk);
      chk("t2_a_ready_after", 32'(tl_o.a_ready), 1);
      chk("t2_dv_after",      32'(tl_o.d_valid), 0);

      // illegal requests: error one cycle after acceptance, register port untouched
      for (int i = 0; i < 4; i++) begin
         step();
         req_total = 0;
         push((il_op[i] == OP_GET) ? 3'd1 : 3'd0, 32'h0, 1'b1, 8'(10 + i), il_size[i]);
         issue(il_op[i], il_addr[i], il_size[i], 8'(10 + i), il_mask[i], 32'h1234_5678, w);
         @(negedge clk);
         chk("t3_dv_lat1",  32'(tl_o.d_valid), 1);
         chk("t3_no_req",   32'(reg_req), 0);
         step();
         @(negedge clk);
         chk("t3_req_total", req_total, 0);
         chk("t3_a_ready",   32'(tl_o.a_ready), 1);
      end

      // timeout with no ack
      step();
      ack_en = 1'b0; req_total = 0;
      push(3'd1, 32'h0, 1'b1, 8'd20, 2'd2);
      issue(OP_GET, 32'h30, 2'd2, 8'd20, 4'hF, 32'h0, w);
      @(negedge clk);
      wait_dvalid(40);
      chk("t4_req_cycles", req_total, 16);
      chk("t4_req_low",    32'(reg_req), 0);

      // ack in the final cycle wins over expiry
      step();
      ack_en = 1'b1; ack_wait = 15; rd_cfg = 32'h12345678; err_cfg = 1'b0; req_total = 0;
      push(3'd1, 32'h12345678, 1'b0, 8'd21, 2'd2);
      issue(OP_GET, 32'h34, 2'd2, 8'd21, 4'hF, 32'h0, w);
      @(negedge clk);
      wait_dvalid(40);
      chk("t4b_req_cycles", req_total, 16);

      // register error on a PutFullData
      step();
      ack_wait = 2; rd_cfg = 32'hCAFE0001; err_cfg = 1'b1; req_total = 0;
      push(3'd0, 32'h0, 1'b1, 8'd22, 2'd2);
      issue(OP_PUT_FULL, 32'h40, 2'd2, 8'd22, 4'hF, 32'h11223344, w);
      @(negedge clk);
      chk("t4c_reg_we", 32'(reg_we), 1);
      wait_dvalid(20);
      chk("t4c_req_cycles", req_total, 3);

      // second request held off while the first is outstanding
      step();
      ack_wait = 3; rd_cfg = 32'h0BADF00D; err_cfg = 1'b0;
      push(3'd1, 32'h0BADF00D, 1'b0, 8'd7, 2'd2);
      push(3'd0, 32'h0, 1'b0, 8'd9, 2'd2);
      issue(OP_GET, 32'h44, 2'd2, 8'd7, 4'hF, 32'h0, w);
      chk("t5_first_wait", w, 0);
      issue(OP_PUT_FULL, 32'h48, 2'd2, 8'd9, 4'hF, 32'h55AA55AA, w);
      chk("t5_second_stall", w, 5);
      @(negedge clk);
      chk("t5_b_addr",  32'(reg_addr), 32'h48);
      chk("t5_b_wdata", reg_wdata, 32'h55AA55AA);
      wait_dvalid(20);

      // reset during ACCESS
      step();
      ack_en = 1'b0;
      issue(OP_GET, 32'h50, 2'd2, 8'd30, 4'hF, 32'h0, w);
      @(negedge clk);
      chk("t6a_req_before", 32'(reg_req), 1);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6a_req",     32'(reg_req), 0);
      chk("t6a_d_valid", 32'(tl_o.d_valid), 0);
      chk("t6a_a_ready", 32'(tl_o.a_ready), 1);

      // reset during RESP
      step();
      ack_en = 1'b1; ack_wait = 0; tl_i.d_ready = 1'b0;
      issue(OP_GET, 32'h54, 2'd2, 8'd31, 4'hF, 32'h0, w);
      @(negedge clk);
      wait_dvalid(10);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6b_req",     32'(reg_req), 0);
      chk("t6b_d_valid", 32'(tl_o.d_valid), 0);
      chk("t6b_a_ready", 32'(tl_o.a_ready), 1);

      // normal Get after the aborts
      step();
      tl_i.d_ready = 1'b1; rd_cfg = 32'h600DCAFE;
      push(3'd1, 32'h600DCAFE, 1'b0, 8'd32, 2'd2);
      issue(OP_GET, 32'h58, 2'd2, 8'd32, 4'hF, 32'h0, w);
      chk("t6c_wait", w, 0);
      @(negedge clk);
      wait_dvalid(10);

      repeat (5) step();
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/student_tlul_device_adapter.md
# student_tlul_device_adapter

Device-side TL-UL responder that terminates one TL-UL link from the address-decoding TL-UL mux and converts each request into a single handshaked access on a simple register port. It accepts one outstanding request at a time and rejects malformed requests with an error response, without touching the register port. It converts a register-side stall into an error response after a programmable timeout. It sits between one mux device output and one peripheral register block.

## Interface

- DATA_WIDTH, 32, TL-UL data width; fixed at 32, mask width 4
- ADDR_WIDTH, 8, number of low address bits forwarded to the register port
- TIMEOUT, 16, max cycles reg_req_o stays high without reg_ack_i before an error response; must be ≥ 2

- clk_i  input  1  clock, all state changes on rising edge
- rst_ni  input  1  reset, synchronous, active-low
- tl_i  input  tlul_pkg::tl_h2d_t  A-channel request and d_ready from the mux
- tl_o  output  tlul_pkg::tl_d2h_t  D-channel response and a_ready to the mux
- reg_req_o  output  1  register access request, held until acknowledged or timed out
- reg_we_o  output  1  1 = write, 0 = read
- reg_addr_o  output  ADDR_WIDTH  tl_i.a_address[ADDR_WIDTH-1:0], captured at acceptance
- reg_wdata_o  output  32  a_data captured at acceptance
- reg_be_o  output  4  a_mask captured at acceptance
- reg_rdata_i  input  32  read data, sampled in the reg_ack_i cycle
- reg_ack_i  input  1  access complete; only meaningful while reg_req_o = 1
- reg_error_i  input  1  access error, sampled in the reg_ack_i cycle

## Operation

- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - a_ready = 1.
  - On a_valid: capture opcode, size, source, address, mask and data.
  - Validate the request. It is legal only if all of the following hold:
    - opcode ∈ {Get = 4, PutFullData = 0, PutPartialData = 1};
    - a_size ≤ 2;
    - a_address[1:0] == 0;
    - PutFullData carries mask 4'hF.
  - Legal request → ACCESS.
  - Illegal request → RESP with d_error = 1 and d_data = 0. The register port is not touched.
- ACCESS:
  - reg_req_o = 1; reg_we_o = 1 for Put*, 0 for Get.
  - On reg_ack_i: capture reg_rdata_i (Get only, otherwise 0) and reg_error_i, then → RESP.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT with no ack: d_error = 1, d_data = 0, → RESP.
- RESP:
  - d_valid = 1.
  - d_opcode = AccessAckData (1) for Get, AccessAck (0) for Put*.
  - d_size and d_source echo the captured request; d_param, d_sink and d_user are 0.
  - All D fields are stable while d_valid && !d_ready.
  - On d_ready → IDLE.
- a_ready = 0 in ACCESS and RESP. Requests arriving there are not consumed; the host holds them.
- Timeout counter: width $clog2(TIMEOUT+1). Cleared on entry to ACCESS. Saturates and never wraps.

## Timing

- Reset (rst_ni = 0 at a rising edge):
  - state = IDLE; counter = 0; all captured registers = 0.
  - Every output is 0, except tl_o.a_ready = 1 from the first cycle after reset.
- Reset mid-transaction aborts it. reg_req_o and d_valid drop the next cycle, and no response is produced.
- Legal request accepted at edge N:
  - reg_req_o is high in cycle N+1.
  - If ack arrives in cycle N+1+k, d_valid is high from cycle N+2+k.
  - Minimum latency from acceptance to d_valid is 2 cycles.
- Illegal request accepted at edge N: d_valid is high in cycle N+1.
- Timeout: with no ack, reg_req_o is high for exactly TIMEOUT cycles. d_valid follows the next cycle.
- If ack and timeout expiry coincide, ack wins: normal response, d_error = reg_error_i.
- d_ready handshake at edge M: a_ready = 1 in cycle M+1. Back-to-back throughput is therefore one transaction per 3 cycles minimum.
- reg_* outputs other than reg_req_o keep their last values outside ACCESS. They are valid only while reg_req_o = 1.

## Test plan

- Get 0x14, source 3, size 2; ack after 0 wait cycles with rdata 0xDEADBEEF → d_valid 2 cycles after acceptance; opcode 1, data 0xDEADBEEF, source 3, error 0.
- PutPartialData addr 0x08, mask 4'b0011, data 0x0000ABCD, with d_ready held low 3 cycles → reg_we_o = 1, reg_be_o = 0011, reg_addr_o = 0x08; D fields stable for 3 cycles, then opcode 0 and error 0; a_ready = 1 the cycle after the d_ready handshake.
- Illegal requests → d_error = 1 one cycle after acceptance, reg_req_o never asserted. Cover each of:
  - opcode 2;
  - address 0x06;
  - PutFullData with mask 4'h7.
- No ack with TIMEOUT = 16 → reg_req_o high exactly 16 cycles; d_error = 1, d_data = 0. Repeat with ack in the 16th cycle and reg_error_i = 0 → d_error = 0.
- Second request presented during ACCESS → a_ready = 0 and it is not consumed; it is accepted in the first IDLE cycle after the first response completes, and both responses carry the correct sources.
- rst_ni low for 1 cycle during ACCESS, then during RESP → next cycle: reg_req_o = 0, d_valid = 0, a_ready = 1; a subsequent Get completes normally.
